axi_console_rx_slave: RTL and testbench
=======================================

// Module: axi_console_rx_slave
// PURPOSE
//  AXI4 128-bit read-only slave serving console INPUT to the CPU: host/bench pushes bytes into an
//  internal FIFO; CPU getchar loads from BASE_ADDR pop one byte. Return path of the 0x01ff_fff0
//  putchar console; sits on the SoC AXI fabric beside x_axi_slave128 (read channels only).
// PARAMETERS
//  ADDR_W     32             AXI address width
//  ID_W       8              AXI ARID/RID width
//  DEPTH      16             FIFO depth in bytes; power of 2, >=2
//  BASE_ADDR  32'h01ff_ffe0  16-byte-aligned register window base
// PORTS
//  clk         in   1        clock
//  rst_b       in   1        reset, asynchronous, active-low
//  arvalid     in   1        AR valid
//  arready     out  1        AR ready
//  araddr      in   ADDR_W   AR address
//  arid        in   ID_W     AR id
//  arlen       in   4        AR beats-1
//  rvalid      out  1        R valid
//  rready      in   1        R ready
//  rdata       out  128      R data
//  rresp       out  2        R resp: 00 OKAY, 10 SLVERR
//  rlast       out  1        R last beat
//  rid         out  ID_W     R id (= latched arid)
//  in_valid    in   1        host byte valid
//  in_ready    out  1        host byte ready (= FIFO not full)
//  in_data     in   8        host byte
//  fifo_count  out  $clog2(DEPTH)+1  bytes held
// BEHAVIOUR
//  - Reset: arready=0 first cycle then 1 in IDLE; rvalid=0, rlast=0, rresp=0, rdata=0, rid=0;
//    FIFO pointers/count=0, in_ready=1 after reset. Reset mid-burst aborts burst, flushes FIFO.
//  - FSM: IDLE -> (arvalid&arready) -> RESP -> (rvalid&rready&rlast) -> IDLE. arready=1 only in IDLE
//    (one outstanding transaction). rvalid asserted cycle after AR handshake, held until rready.
//  - Decode on AR handshake, off = araddr - BASE_ADDR:
//    off 0x0 DATA: if FIFO non-empty pop one byte, word = {1'b1,23'b0,byte}; else word = 0, no pop.
//    off 0x4 STATUS: word = {16'b0, fifo_count zero-extended to 16}; no pop.
//    off 0x8/0xC: word = 0, OKAY. Outside window: word = 0, rresp=SLVERR all beats.
//  - Word placed in lane araddr[3:2] of rdata (rdata[32*lane+:32]); other lanes 0.
//  - Bursts: beats = arlen+1; every beat returns same rdata/rresp; DATA pops exactly once per
//    transaction (at AR accept); beat counter decrements on rvalid&rready; rlast on final beat.
//  - FIFO push on in_valid&in_ready. in_ready=!full from registered count; push+pop same cycle:
//    count unchanged; pop only when non-empty; push at full impossible (no overflow state).
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1 so full=DEPTH representable.
//  - FIFO read data captured into rdata register at AR accept: 1-cycle AR->R latency, fixed.
// STRUCTURE
//  - Package console_pkg: DATA/STATUS offsets, RESP_OKAY/RESP_SLVERR, state enum {IDLE,RESP},
//    shared with putchar console logic.
//  - Sub-module console_sync_fifo (DEPTH x 8, push/pop/count/full/empty); FSM+decode in top.
// TESTING
//  - Push 'A'(0x41), read BASE_ADDR len0 -> rdata[31:0]=0x8000_0041, rlast=1, OKAY; count 1->0.
//  - Read DATA with empty FIFO -> rdata=0, OKAY, count stays 0, pointers unchanged.
//  - Push DEPTH bytes -> in_ready=0, count=16; extra in_valid ignored; STATUS read at BASE+4 ->
//    rdata[63:32]=0x0000_0010.
//  - DATA read len=3 with rready toggling -> 4 beats identical, rlast on 4th only, one pop.
//  - Read 0x0200_0000 -> rresp=SLVERR, rdata=0, rid=arid; simultaneous push+pop keeps count.
//  - Assert rst_b low during beat 2 of burst -> rvalid=0 async, count=0, arready=1 after release.

Source files
------------

// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared console register map, response codes and FSM states
package console_pkg;

  localparam logic [1:0] WSEL_DATA   = 2'd0;
  localparam logic [1:0] WSEL_STATUS = 2'd1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Bit 31 flags a valid byte so getchar can tell "no input" apart from a NUL byte.
  function automatic logic [31:0] data_word(input logic [7:0] b);
    return {1'b1, 23'b0, b};
  endfunction

endpackage

// File: rtl/axi_console_rx_slave_if.sv
// rtl/axi_console_rx_slave_if.sv - AXI4 read-channel bundle (AR + R) for the console rx slave
interface axi_console_rx_slave_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [3:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic [127:0]      rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/console_sync_fifo.sv
// rtl/console_sync_fifo.sv - DEPTH x 8 synchronous byte FIFO with occupancy count
module console_sync_fifo #(
  parameter int  DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/axi_console_rx_slave.sv
// rtl/axi_console_rx_slave.sv - AXI4 128-bit read-only slave feeding host bytes to CPU getchar
module axi_console_rx_slave
  import console_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          ID_W      = 8,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h01ff_ffe0,
  localparam int         CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  axi_console_rx_slave_if.slave axi,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [7:0]            in_data_i,
  output logic [CNT_W-1:0]      fifo_count_o
);
  state_e            state_q, state_d;
  logic              arready_q;
  logic [127:0]      rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [3:0]        beats_q, beats_d;
  logic              ar_hs, r_hs, rvalid;
  logic [ADDR_W-1:0] off;
  logic              in_window;
  logic [1:0]        word_sel;
  logic [31:0]       word;
  logic              pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;

  console_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push_i  (in_valid_i),
    .data_i  (in_data_i),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .count_o (fifo_count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign off       = axi.araddr - ADDR_W'(BASE_ADDR);
  assign in_window = ((off >> 4) == '0);
  assign word_sel  = off[3:2];
  assign ar_hs     = axi.arvalid && arready_q;
  assign rvalid    = (state_q == ST_RESP);
  assign r_hs      = rvalid && axi.rready;

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rvalid && (beats_q == 4'd0);
  assign axi.rid     = rid_q;
  assign in_ready_o  = !fifo_full;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rid_d   = rid_q;
    beats_d = beats_q;
    pop     = 1'b0;
    word    = '0;
    if (in_window) begin
      case (word_sel)
        WSEL_DATA:   word = fifo_empty ? 32'h0 : data_word(fifo_rdata);
        WSEL_STATUS: word = {16'b0, 16'(fifo_count_o)};
        default:     word = '0;
      endcase
    end
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          // The whole burst replays this captured word, so DATA pops only here.
          state_d = ST_RESP;
          rdata_d = '0;
          rdata_d[{word_sel, 5'd0} +: 32] = word;
          rresp_d = in_window ? RESP_OKAY : RESP_SLVERR;
          rid_d   = axi.arid;
          beats_d = axi.arlen;
          pop     = in_window && (word_sel == WSEL_DATA) && !fifo_empty;
        end
      end
      ST_RESP: begin
        if (r_hs) begin
          if (beats_q == 4'd0) state_d = ST_IDLE;
          else                 beats_d = beats_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      beats_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == ST_IDLE);
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      beats_q   <= beats_d;
    end
  end
endmodule

// File: tb/tb_axi_console_rx_slave.sv
// tb/tb_axi_console_rx_slave.sv - randomized self-checking bench with queue-based console model
module tb_axi_console_rx_slave;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h01ff_ffe0;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic [4:0] fifo_count;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q[$];

  always #5 clk = ~clk;

  axi_console_rx_slave_if #(.ADDR_W(32), .ID_W(8)) axi ();

  axi_console_rx_slave #(.ADDR_W(32), .ID_W(8), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .axi          (axi.slave),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .fifo_count_o (fifo_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  // Reference: register map applied to the byte queue, optional host push in the same cycle.
  task automatic model_read(input logic [31:0] addr, input bit push_en, input logic [7:0] push_val,
                            output logic [127:0] exp_data, output logic [1:0] exp_resp);
    logic [31:0] off;
    logic [31:0] word;
    int          idx;
    bit          full_before;
    off         = addr - BASE;
    exp_data    = '0;
    exp_resp    = 2'b00;
    word        = '0;
    full_before = (model_q.size() == DEPTH);
    if (off >= 32'd16) begin
      exp_resp = 2'b10;
    end else begin
      idx = int'(off) / 4;
      if (idx == 0 && model_q.size() > 0) begin
        word = 32'h8000_0000 + {24'b0, model_q[0]};
        void'(model_q.pop_front());
      end else if (idx == 1) begin
        word = 32'(model_q.size());
      end
      exp_data = 128'(word) << (32 * idx);
    end
    if (push_en && !full_before) model_q.push_back(push_val);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] id, input logic [3:0] len,
                          input bit toggle, input bit push_en, input logic [7:0] push_val,
                          output logic [127:0] first_data, output logic [1:0] first_resp,
                          output logic [7:0] first_rid, output int nbeats, output bit consistent,
                          output int nlast, output int last_idx, output bit lat_ok,
                          output bit timed_out);
    int cyc;
    bit done;
    timed_out = 1'b0; nbeats = 0; consistent = 1'b1; nlast = 0; last_idx = -1;
    lat_ok = 1'b0; first_data = '0; first_resp = '0; first_rid = '0; done = 1'b0;
    cyc = 0;
    while (!axi.arready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!axi.arready) begin
      timed_out = 1'b1;
      return;
    end
    axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id; axi.arlen = len;
    in_valid = push_en; in_data = push_val;
    tick();
    axi.arvalid = 1'b0;
    in_valid    = 1'b0;
    lat_ok      = axi.rvalid;
    cyc = 0;
    while (cyc < 200 && !done) begin
      axi.rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (axi.rvalid && axi.rready) begin
        if (nbeats == 0) begin
          first_data = axi.rdata; first_resp = axi.rresp; first_rid = axi.rid;
        end else if (axi.rdata !== first_data || axi.rresp !== first_resp || axi.rid !== first_rid) begin
          consistent = 1'b0;
        end
        if (axi.rlast) begin
          nlast++;
          if (last_idx < 0) last_idx = nbeats;
          done = 1'b1;
        end
        nbeats++;
      end
      tick();
      cyc++;
    end
    axi.rready = 1'b0;
    if (!done) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if (axi.arready !== 1'b0 || axi.rvalid !== 1'b0 || axi.rlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: arready=%b rvalid=%b rlast=%b, expected 0 0 0", axi.arready, axi.rvalid, axi.rlast);
    end
    checks++;
    if (axi.rdata !== 128'h0 || axi.rresp !== 2'b00 || axi.rid !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h rresp=%b rid=%h, expected zeros", axi.rdata, axi.rresp, axi.rid);
    end
    checks++;
    if (fifo_count !== 5'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo: count=%0d in_ready=%b, expected 0 1", fifo_count, in_ready);
    end
    rst_b = 1'b1;
    #1;
    checks++;
    if (axi.arready !== 1'b0) begin
      errors++;
      $display("FAIL reset_arready_first: got %b expected 0", axi.arready);
    end
    tick();
    checks++;
    if (axi.arready !== 1'b1) begin
      errors++;
      $display("FAIL reset_arready_idle: got %b expected 1", axi.arready);
    end
  endtask

  task automatic test_data_read();
    logic [127:0] d, ed; logic [1:0] r, er; logic [7:0] id;
    int nb, nl, li; bit cons, lat, to;
    push_byte(8'h41);
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL data_count_before: got %0d expected 1", fifo_count);
    end
    model_read(BASE, 1'b0, 8'h00, ed, er);
    axi_read(BASE, 8'h5a, 4'd0, 1'b0, 1'b0, 8'h00, d, r, id, nb, cons, nl, li, lat, to);
    checks++;
    if (d !== ed || d[31:0] !== 32'h8000_0041 || r !== 2'b00) begin
      errors++;
      $display("FAIL data_read: rdata=%h rresp=%b, expected %h 00", d, r, ed);
    end
    checks++;
    if (to || !lat || nb != 1 || nl != 1 || id !== 8'h5a) begin
      errors++;
      $display("FAIL data_handshake: timeout=%b lat=%b beats=%0d lasts=%0d rid=%h, expected 0 1 1 1 5a", to, lat, nb, nl, id);
    end
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL data_count_after: got %0d expected 0", fifo_count);
    end
  endtask

  task automatic test_empty_read();
    logic [127:0] d, ed; logic [1:0] r, er; logic [7:0] id;
    int nb, nl, li; bit cons, lat, to;
    model_read(BASE, 1'b0, 8'h00, ed, er);
    axi_read(BASE, 8'h03, 4'd0, 1'b0, 1'b0, 8'h00, d, r, id, nb, cons, nl, li, lat, to);
    checks++;
    if (to || d !== 128'h0 || r !== 2'b00 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL empty_read: timeout=%b rdata=%h rresp=%b count=%0d, expected 0 0 00 0", to, d, r, fifo_count);
    end
    push_byte(8'h77);
    model_read(BASE, 1'b0, 8'h00, ed, er);
    axi_read(BASE, 8'h04, 4'd0, 1'b0, 1'b0, 8'h00, d, r, id, nb, cons, nl, li, lat, to);
    checks++;
    if (to || d !== ed) begin
      errors++;
      $display("FAIL empty_then_push: timeout=%b rdata=%h expected %h", to, d, ed);
    end
  endtask

  task automatic test_full_status();
    logic [127:0] d, ed; logic [1:0] r, er; logic [7:0] id;
    int nb, nl, li; bit cons, lat, to; bit order_ok;
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
    checks++;
    if (in_ready !== 1'b0 || fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL full_flags: in_ready=%b count=%0d, expected 0 16", in_ready, fifo_count);
    end
    push_byte(8'hee);
    checks++;
    if (fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL full_overflow: count=%0d expected 16", fifo_count);
    end
    model_read(BASE + 32'd4, 1'b0, 8'h00, ed, er);
    axi_read(BASE + 32'd4, 8'h11, 4'd0, 1'b0, 1'b0, 8'h00, d, r, id, nb, cons, nl, li, lat, to);
    checks++;
    if (to || d !== ed || d[63:32] !== 32'h0000_0010 || r !== 2'b00) begin
      errors++;
      $display("FAIL status_full: rdata=%h rresp=%b expected %h 00", d, r, ed);
    end
    order_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      model_read(BASE, 1'b0, 8'h00, ed, er);
      axi_read(BASE, 8'(i), 4'd0, 1'b0, 1'b0, 8'h00, d, r, id, nb, cons, nl, li, lat, to);
      if (to || d !== ed) order_ok = 1'b0;
    end
    checks++;
    if (!order_ok || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL full_drain: order_ok=%b count=%0d, expected 1 0", order_ok, fifo_count);
    end
  endtask

  task automatic test_burst();
    logic [127:0] d, ed; logic [1:0] r, er; logic [7:0] id;
    int nb, nl, li; bit cons, lat, to;
    push_byte(8'h5c);
    push_byte(8'h3d);
    model_read(BASE, 1'b0, 8'h00, ed, er);
    axi_read(BASE, 8'h21, 4'd3, 1'b1, 1'b0, 8'h00, d, r, id, nb, cons, nl, li, lat, to);
    checks++;
    if (to || nb != 4 || !cons || nl != 1 || li != 3) begin
      errors++;
      $display("FAIL burst_beats: timeout=%b beats=%0d same=%b lasts=%0d last_at=%0d, expected 0 4 1 1 3", to, nb, cons, nl, li);
    end
    checks++;
    if (d !== ed || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL burst_pop_once: rdata=%h count=%0d, expected %h 1", d, fifo_count, ed);
    end
  endtask

  task automatic test_slverr_simul();
    logic [127:0] d, ed; logic [1:0] r, er; logic [7:0] id;
    int nb, nl, li; bit cons, lat, to;
    model_read(32'h0200_0000, 1'b0, 8'h00, ed, er);
    axi_read(32'h0200_0000, 8'hc3, 4'd1, 1'b0, 1'b0, 8'h00, d, r, id, nb, cons, nl, li, lat, to);
    checks++;
    if (to || r !== 2'b10 || d !== 128'h0 || id !== 8'hc3 || nb != 2 || !cons) begin
      errors++;
      $display("FAIL slverr: timeout=%b rresp=%b rdata=%h rid=%h beats=%0d same=%b, expected 0 10 0 c3 2 1", to, r, d, id, nb, cons);
    end
    push_byte(8'h90);
    model_read(BASE, 1'b1, 8'h91, ed, er);
    axi_read(BASE, 8'h44, 4'd0, 1'b0, 1'b1, 8'h91, d, r, id, nb, cons, nl, li, lat, to);
    checks++;
    if (to || d !== ed || fifo_count !== 5'd2 || fifo_count !== 5'(model_q.size())) begin
      errors++;
      $display("FAIL push_pop_same: rdata=%h count=%0d, expected %h 2", d, fifo_count, ed);
    end
  endtask

  task automatic test_random();
    logic [127:0] d, ed; logic [1:0] r, er; logic [7:0] id, rid_req, pv;
    logic [31:0] addr; logic [3:0] len;
    int nb, nl, li, sel; bit cons, lat, to, tg, pe;
    for (int it = 0; it < 40; it++) begin
      for (int k = $urandom_range(0, 4); k > 0; k--) push_byte(8'($urandom));
      sel = $urandom_range(0, 6);
      if (sel < 4)       addr = BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
      else if (sel == 4) addr = BASE + 32'd16 + 32'($urandom_range(0, 255));
      else if (sel == 5) addr = BASE - 32'($urandom_range(1, 64));
      else               addr = BASE;
      len = 4'($urandom_range(0, 3));
      tg = 1'($urandom_range(0, 1));
      pe = 1'($urandom_range(0, 1));
      pv = 8'($urandom);
      rid_req = 8'($urandom);
      model_read(addr, pe, pv, ed, er);
      axi_read(addr, rid_req, len, tg, pe, pv, d, r, id, nb, cons, nl, li, lat, to);
      checks++;
      if (to || d !== ed || r !== er || id !== rid_req) begin
        errors++;
        $display("FAIL rand_data[%0d]: addr=%h timeout=%b rdata=%h rresp=%b rid=%h, expected %h %b %h", it, addr, to, d, r, id, ed, er, rid_req);
      end
      checks++;
      if (!lat || nb != int'(len) + 1 || !cons || nl != 1 || li != int'(len)) begin
        errors++;
        $display("FAIL rand_burst[%0d]: lat=%b beats=%0d same=%b lasts=%0d last_at=%0d, expected 1 %0d 1 1 %0d", it, lat, nb, cons, nl, li, int'(len) + 1, len);
      end
      checks++;
      if (fifo_count !== 5'(model_q.size())) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", it, fifo_count, model_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h60 + i));
    cyc = 0;
    while (!axi.arready && cyc < 50) begin
      tick();
      cyc++;
    end
    axi.arvalid = 1'b1; axi.araddr = BASE; axi.arid = 8'h09; axi.arlen = 4'd3;
    tick();
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    tick();
    axi.rready = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b1 || axi.rlast !== 1'b0) begin
      errors++;
      $display("FAIL midburst_beat2: rvalid=%b rlast=%b, expected 1 0", axi.rvalid, axi.rlast);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (axi.rvalid !== 1'b0 || fifo_count !== 5'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midburst_async: rvalid=%b count=%0d in_ready=%b, expected 0 0 1", axi.rvalid, fifo_count, in_ready);
    end
    model_q.delete();
    #1 rst_b = 1'b1;
    tick();
    checks++;
    if (axi.arready !== 1'b1) begin
      errors++;
      $display("FAIL midburst_arready: got %b expected 1", axi.arready);
    end
  endtask

  initial begin
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arid = '0; axi.arlen = '0; axi.rready = 1'b0;
    in_valid = 1'b0; in_data = '0;
    test_reset();
    test_data_read();
    test_empty_read();
    test_full_status();
    test_burst();
    test_slverr_simul();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
